// File: rtl/addr_gen_wr_if.sv
`default_nettype none
// ============================================================================
// Module      : addr_gen_wr_if
// Description : Upstream handshake plus memory write port of addr_gen_wr.
// Revision    : 1.0 - initial release
// ============================================================================
interface addr_gen_wr_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  en;
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_ready;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_we;
    logic                  o_done;

    modport master (
        output en,
        output i_valid,
        output i_data,
        input  o_ready,
        input  o_addr,
        input  o_data,
        input  o_we,
        input  o_done
    );

    modport slave (
        input  en,
        input  i_valid,
        input  i_data,
        output o_ready,
        output o_addr,
        output o_data,
        output o_we,
        output o_done
    );
endinterface
`default_nettype wire

// File: rtl/addr_gen_wr.sv
`default_nettype none
// ============================================================================
// Module      : addr_gen_wr
// Description : Sequential memory write-address generator with row pauses.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_gen_wr #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int START      = 0,
    parameter int STOP       = 56,
    parameter int ROW_LEN    = 8,
    parameter int PAUSE_LEN  = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    addr_gen_wr_if.slave  bus
);

    localparam int c_ROW_W   = (ROW_LEN   > 1) ? $clog2(ROW_LEN)   : 1;
    localparam int c_PAUSE_W = (PAUSE_LEN > 1) ? $clog2(PAUSE_LEN) : 1;

    localparam logic [ADDR_WIDTH-1:0] c_START      = ADDR_WIDTH'(START);
    localparam logic [ADDR_WIDTH-1:0] c_STOP       = ADDR_WIDTH'(STOP);
    localparam logic [c_ROW_W-1:0]    c_ROW_LAST   = c_ROW_W'(ROW_LEN - 1);
    localparam logic [c_PAUSE_W-1:0]  c_PAUSE_LAST = c_PAUSE_W'((PAUSE_LEN > 0) ? PAUSE_LEN - 1 : 0);
    localparam bit                    c_HAS_PAUSE  = (PAUSE_LEN > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [c_ROW_W-1:0]    r_row;
    logic [c_PAUSE_W-1:0]  r_pause;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_we;
    logic                  r_done;

    logic                  w_ready;

    // Ready is only offered in WRITE and only while enabled.
    assign w_ready     = bus.en && (r_state == S_WRITE);

    assign bus.o_ready = w_ready;
    assign bus.o_addr  = r_addr;
    assign bus.o_data  = r_data;
    assign bus.o_we    = r_we;
    assign bus.o_done  = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wptr  <= c_START;
            r_row   <= '0;
            r_pause <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (bus.en) begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_WRITE;
                    end

                    S_WRITE: begin
                        if (bus.i_valid) begin
                            r_addr <= r_wptr;
                            r_data <= bus.i_data;
                            r_we   <= 1'b1;
                            // The final address ends the run even if it also closes a row.
                            if (r_wptr == c_STOP) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_wptr <= r_wptr + 1'b1;
                                if (r_row == c_ROW_LAST) begin
                                    r_row <= '0;
                                    if (c_HAS_PAUSE) begin
                                        r_state <= S_PAUSE;
                                    end
                                end else begin
                                    r_row <= r_row + 1'b1;
                                end
                            end
                        end
                    end

                    S_PAUSE: begin
                        if (r_pause == c_PAUSE_LAST) begin
                            r_pause <= '0;
                            r_state <= S_WRITE;
                        end else begin
                            r_pause <= r_pause + 1'b1;
                        end
                    end

                    S_DONE: begin
                        r_state <= S_DONE;
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addr_gen_wr.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_gen_wr
// Description : Self-checking bench for addr_gen_wr (default and no-pause DUTs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_gen_wr;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    addr_gen_wr_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) b1 ();
    addr_gen_wr_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) b2 ();

    addr_gen_wr #(
        .ADDR_WIDTH(12), .DATA_WIDTH(16), .START(0), .STOP(56), .ROW_LEN(8), .PAUSE_LEN(2)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    addr_gen_wr #(
        .ADDR_WIDTH(12), .DATA_WIDTH(16), .START(4), .STOP(9), .ROW_LEN(2), .PAUSE_LEN(0)
    ) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    typedef struct {
        logic        en;
        logic        valid;
        logic [15:0] data;
        logic        ready;
        logic        we;
        logic [11:0] addr;
        logic [15:0] odata;
        logic        done;
    } vec_t;

    vec_t        vecs [10];
    logic [15:0] sb [$];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Leaves the bench at posedge+2 with reset released and all inputs idle.
    task automatic do_reset();
        rst        = 1'b1;
        b1.en      = 1'b0;
        b1.i_valid = 1'b0;
        b1.i_data  = '0;
        b2.en      = 1'b0;
        b2.i_valid = 1'b0;
        b2.i_data  = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Streams words into DUT1 until the write of 'target' is seen; returns at that negedge.
    task automatic run_until(input logic [11:0] target, input int budget);
        bit hit;
        hit        = 1'b0;
        b1.en      = 1'b1;
        b1.i_valid = 1'b1;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            if (b1.o_we && b1.o_addr == target) begin
                hit = 1'b1;
            end else begin
                @(posedge clk);
                #2;
            end
        end
        chk("reach_addr", 32'(hit), 32'd1);
    endtask

    initial begin
        int  n_we, exp_a, low_run, n_gaps;
        bit  started, fin, hit;
        logic [15:0] want_d;

        b1.en = 1'b0; b1.i_valid = 1'b0; b1.i_data = '0;
        b2.en = 1'b0; b2.i_valid = 1'b0; b2.i_data = '0;

        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        #1;
        chk("rst_we",    32'(b1.o_we),    32'd0);
        chk("rst_addr",  32'(b1.o_addr),  32'd0);
        chk("rst_data",  32'(b1.o_data),  32'd0);
        chk("rst_done",  32'(b1.o_done),  32'd0);
        chk("rst_ready", 32'(b1.o_ready), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // ---------------- table: toggled valid and an en drop ----------------
        vecs[0] = '{1'b1, 1'b1, 16'h00A0, 1'b0, 1'b0, 12'd0, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 12'd0, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h2222, 1'b1, 1'b1, 12'd0, 16'h1111, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'h3333, 1'b1, 1'b0, 12'd0, 16'h1111, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h4444, 1'b1, 1'b1, 12'd1, 16'h3333, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 12'd1, 16'h3333, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h6666, 1'b0, 1'b1, 12'd2, 16'h5555, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 16'h7777, 1'b1, 1'b0, 12'd2, 16'h5555, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 16'h8888, 1'b1, 1'b1, 12'd3, 16'h7777, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, 12'd3, 16'h7777, 1'b0};

        for (int i = 0; i < 10; i++) begin
            b1.en      = vecs[i].en;
            b1.i_valid = vecs[i].valid;
            b1.i_data  = vecs[i].data;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 32'(b1.o_ready), 32'(vecs[i].ready));
            chk($sformatf("vec%0d_we",    i), 32'(b1.o_we),    32'(vecs[i].we));
            chk($sformatf("vec%0d_addr",  i), 32'(b1.o_addr),  32'(vecs[i].addr));
            chk($sformatf("vec%0d_data",  i), 32'(b1.o_data),  32'(vecs[i].odata));
            chk($sformatf("vec%0d_done",  i), 32'(b1.o_done),  32'(vecs[i].done));
            @(posedge clk);
            #2;
        end

        // ---------------- continuous full run ----------------
        do_reset();
        b1.en      = 1'b1;
        b1.i_valid = 1'b1;
        b1.i_data  = 16'hA000;
        n_we = 0; exp_a = 0; low_run = 0; n_gaps = 0; started = 1'b0; fin = 1'b0;
        sb.delete();
        for (int c = 0; c < 150 && !fin; c++) begin
            @(negedge clk);
            if (b1.o_we) begin
                want_d = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
                chk("cont_addr", 32'(b1.o_addr), 32'(exp_a));
                chk("cont_data", 32'(b1.o_data), 32'(want_d));
                chk("cont_done", 32'(b1.o_done), 32'(exp_a == 56));
                exp_a++;
                n_we++;
                if (b1.o_done) fin = 1'b1;
            end
            if (b1.o_ready) begin
                if (started && low_run > 0) begin
                    chk("gap_len", 32'(low_run), 32'd2);
                    n_gaps++;
                end
                low_run = 0;
                started = 1'b1;
            end else if (started && !b1.o_done) begin
                low_run++;
            end
            if (b1.o_ready && b1.i_valid) sb.push_back(b1.i_data);
            @(posedge clk);
            #2;
            b1.i_data = 16'hA000 + 16'(c + 1);
        end
        chk("cont_count", 32'(n_we),      32'd57);
        chk("cont_gaps",  32'(n_gaps),    32'd7);
        chk("cont_fin",   32'(b1.o_done), 32'd1);

        // Valid held high in DONE, including a cycle with en low.
        for (int k = 0; k < 4; k++) begin
            b1.en = (k != 2);
            @(negedge clk);
            chk("done_we",    32'(b1.o_we),    32'd0);
            chk("done_addr",  32'(b1.o_addr),  32'd56);
            chk("done_ready", 32'(b1.o_ready), 32'd0);
            chk("done_flag",  32'(b1.o_done),  32'd1);
            @(posedge clk);
            #2;
        end

        // ---------------- en dropped during the pause after addr 7 ----------------
        do_reset();
        run_until(12'd7, 40);
        chk("p0_ready", 32'(b1.o_ready), 32'd0);
        @(posedge clk);
        #2;
        b1.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("pen_ready", 32'(b1.o_ready), 32'd0);
            chk("pen_we",    32'(b1.o_we),    32'd0);
            chk("pen_addr",  32'(b1.o_addr),  32'd7);
            @(posedge clk);
            #2;
        end
        b1.en = 1'b1;
        @(negedge clk);
        chk("pext_ready", 32'(b1.o_ready), 32'd0);
        chk("pext_we",    32'(b1.o_we),    32'd0);
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("presume_ready", 32'(b1.o_ready), 32'd1);
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("presume_we",   32'(b1.o_we),   32'd1);
        chk("presume_addr", 32'(b1.o_addr), 32'd8);

        // ---------------- asynchronous reset mid-run ----------------
        @(posedge clk);
        #2;
        do_reset();
        run_until(12'd20, 60);
        #1 rst = 1'b1;
        #1;
        chk("arst_we",    32'(b1.o_we),    32'd0);
        chk("arst_addr",  32'(b1.o_addr),  32'd0);
        chk("arst_data",  32'(b1.o_data),  32'd0);
        chk("arst_done",  32'(b1.o_done),  32'd0);
        chk("arst_ready", 32'(b1.o_ready), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clk);
            if (b1.o_we) begin
                hit = 1'b1;
                chk("restart_addr", 32'(b1.o_addr), 32'd0);
            end
            @(posedge clk);
            #2;
        end
        chk("restart_seen", 32'(hit), 32'd1);

        // ---------------- no-pause DUT: START=4 STOP=9 ROW_LEN=2 ----------------
        do_reset();
        b2.en      = 1'b1;
        b2.i_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            b2.i_data = 16'h0B00 + 16'(k);
            @(negedge clk);
            chk($sformatf("np%0d_ready", k), 32'(b2.o_ready), 32'(k >= 1 && k <= 6));
            chk($sformatf("np%0d_we",    k), 32'(b2.o_we),    32'(k >= 2 && k <= 7));
            chk($sformatf("np%0d_addr",  k), 32'(b2.o_addr),
                (k < 2) ? 32'd0 : ((k <= 7) ? 32'(k + 2) : 32'd9));
            chk($sformatf("np%0d_data",  k), 32'(b2.o_data),
                (k < 2) ? 32'd0 : ((k <= 7) ? 32'(16'h0B00 + k - 1) : 32'h0B06));
            chk($sformatf("np%0d_done",  k), 32'(b2.o_done),  32'(k >= 7));
            @(posedge clk);
            #2;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
